// File: rtl/oflow_cr_score_scan.sv
// Conflict-resolve scanner: walks one PE score board, forces losing rows to their fallback, rescans.
// Latency: N+2 cycles per pass, done_cr one cycle after the last pass's CHECK (N=0: done in cycle 2).
// Backpressure: none; start_cr is ignored while busy_cr is high, PE read data is assumed one cycle after select.
module oflow_cr_score_scan #(
  parameter int SCORE_LEN  = 32,
  parameter int ID_LEN     = 7,
  parameter int ROW_LEN    = 5,
  parameter int MAX_PASSES = 4
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_cr,
  input  logic [ROW_LEN-1:0]   num_of_rows,
  input  logic [SCORE_LEN-1:0] score_to_cr_from_pe,
  input  logic [ID_LEN-1:0]    id_to_cr_from_pe,
  output logic [ROW_LEN-1:0]   row_sel_to_pe_from_cr,
  output logic                 write_to_pointer_to_pe,
  output logic                 data_to_score_board_to_pe,
  output logic [ROW_LEN-1:0]   row_to_change_to_pe,
  output logic                 busy_cr,
  output logic                 done_cr,
  output logic [7:0]           conflict_cnt,
  output logic                 unresolved
);

  localparam int         NID   = 1 << ID_LEN;
  localparam logic [7:0] MAX_P = 8'(MAX_PASSES);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_CHECK, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ROW_LEN-1:0]   n_q, n_d;
  logic [ROW_LEN-1:0]   scan_row_q, scan_row_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [ROW_LEN-1:0]   rd_row_q, rd_row_d;
  logic [7:0]           pass_q, pass_d;
  logic                 pass_wb_q, pass_wb_d;
  logic                 wr_q, wr_d;
  logic [ROW_LEN-1:0]   wr_row_q, wr_row_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 unres_q, unres_d;
  logic [NID-1:0]       claim_vld_q, claim_vld_d;
  logic [SCORE_LEN-1:0] claim_score_q [NID];
  logic [ROW_LEN-1:0]   claim_row_q [NID];

  logic                 claim_we;
  logic                 cmp_wb;
  logic [ROW_LEN-1:0]   cmp_loser;

  // Compare the arriving row against the claim table; decide claim update and the losing row.
  always_comb begin
    claim_we  = 1'b0;
    cmp_wb    = 1'b0;
    cmp_loser = '0;
    if (rd_vld_q && (id_to_cr_from_pe != '1)) begin
      if (!claim_vld_q[id_to_cr_from_pe]) begin
        claim_we = 1'b1;
      end else if (score_to_cr_from_pe < claim_score_q[id_to_cr_from_pe]) begin
        // New row is strictly better: it takes the ID, previous holder falls back.
        claim_we  = 1'b1;
        cmp_wb    = 1'b1;
        cmp_loser = claim_row_q[id_to_cr_from_pe];
      end else begin
        // Worse or tied: the earlier row keeps the ID.
        cmp_wb    = 1'b1;
        cmp_loser = rd_row_q;
      end
    end
  end

  // Claim table payload; only the valid bits need a reset/clear.
  always_ff @(posedge clk) begin
    if (claim_we) begin
      claim_score_q[id_to_cr_from_pe] <= score_to_cr_from_pe;
      claim_row_q[id_to_cr_from_pe]   <= rd_row_q;
    end
  end

  // Next-state, pass bookkeeping, write-back and statistics.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    scan_row_d  = scan_row_q;
    rd_vld_d    = 1'b0;
    rd_row_d    = '0;
    pass_d      = pass_q;
    pass_wb_d   = pass_wb_q;
    wr_d        = 1'b0;
    wr_row_d    = '0;
    cnt_d       = cnt_q;
    unres_d     = unres_q;
    claim_vld_d = claim_vld_q;

    if (claim_we) begin
      claim_vld_d[id_to_cr_from_pe] = 1'b1;
    end
    if (cmp_wb) begin
      wr_d      = 1'b1;
      wr_row_d  = cmp_loser;
      pass_wb_d = 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_cr) begin
          n_d         = num_of_rows;
          cnt_d       = '0;
          unres_d     = 1'b0;
          pass_d      = 8'd1;
          pass_wb_d   = 1'b0;
          claim_vld_d = '0;
          scan_row_d  = '0;
          state_d     = (num_of_rows == '0) ? S_CHECK : S_SCAN;
        end
      end
      S_SCAN: begin
        rd_vld_d = 1'b1;
        rd_row_d = scan_row_q;
        if (scan_row_q == n_q - 1'b1) begin
          state_d = S_DRAIN;
        end else begin
          scan_row_d = scan_row_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // The last row's write-back commits this cycle, so a rescan reads settled pointers.
        if (pass_wb_q && (pass_q < MAX_P)) begin
          pass_d      = pass_q + 8'd1;
          pass_wb_d   = 1'b0;
          claim_vld_d = '0;
          scan_row_d  = '0;
          state_d     = S_SCAN;
        end else begin
          unres_d = pass_wb_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      scan_row_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_row_q    <= '0;
      pass_q      <= '0;
      pass_wb_q   <= 1'b0;
      wr_q        <= 1'b0;
      wr_row_q    <= '0;
      cnt_q       <= '0;
      unres_q     <= 1'b0;
      claim_vld_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      scan_row_q  <= scan_row_d;
      rd_vld_q    <= rd_vld_d;
      rd_row_q    <= rd_row_d;
      pass_q      <= pass_d;
      pass_wb_q   <= pass_wb_d;
      wr_q        <= wr_d;
      wr_row_q    <= wr_row_d;
      cnt_q       <= cnt_d;
      unres_q     <= unres_d;
      claim_vld_q <= claim_vld_d;
    end
  end

  assign row_sel_to_pe_from_cr     = (state_q == S_SCAN) ? scan_row_q : '0;
  assign write_to_pointer_to_pe    = wr_q;
  assign data_to_score_board_to_pe = wr_q;
  assign row_to_change_to_pe       = wr_row_q;
  assign busy_cr                   = (state_q != S_IDLE);
  assign done_cr                   = (state_q == S_DONE);
  assign conflict_cnt              = cnt_q;
  assign unresolved                = unres_q;

endmodule

// File: tb/tb_oflow_cr_score_scan.sv
// Bench for oflow_cr_score_scan: PE score board model, pass-level reference model, scoreboard monitor.
// Latency: checks select/write/done cycles relative to the start cycle.
// Backpressure: none; the PE model answers one cycle after each select.
module tb_oflow_cr_score_scan;

  localparam int MAXP  = 4;
  localparam int NCAND = 6;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start_cr;
  logic [4:0]  num_of_rows;
  logic [31:0] pe_sc;
  logic [6:0]  pe_id;
  logic [4:0]  row_sel;
  logic        wr_stb;
  logic        wr_dat;
  logic [4:0]  wr_row;
  logic        busy_cr;
  logic        done_cr;
  logic [7:0]  conflict_cnt;
  logic        unresolved;

  oflow_cr_score_scan #(.SCORE_LEN(32), .ID_LEN(7), .ROW_LEN(5), .MAX_PASSES(MAXP)) dut (
    .clk                       (clk),
    .reset_N                   (reset_N),
    .start_cr                  (start_cr),
    .num_of_rows               (num_of_rows),
    .score_to_cr_from_pe       (pe_sc),
    .id_to_cr_from_pe          (pe_id),
    .row_sel_to_pe_from_cr     (row_sel),
    .write_to_pointer_to_pe    (wr_stb),
    .data_to_score_board_to_pe (wr_dat),
    .row_to_change_to_pe       (wr_row),
    .busy_cr                   (busy_cr),
    .done_cr                   (done_cr),
    .conflict_cnt              (conflict_cnt),
    .unresolved                (unresolved)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PE score board: per row an ordered list of candidates; a write-back advances the row's pointer.
  logic [6:0]  cand_id [32][NCAND];
  logic [31:0] cand_sc [32][NCAND];
  int          pe_ptr [32];

  always @(posedge clk) begin
    if (!busy_cr) begin
      for (int i = 0; i < 32; i++) pe_ptr[i] <= 0;
    end else if (wr_stb && wr_dat && pe_ptr[wr_row] < NCAND - 1) begin
      pe_ptr[wr_row] <= pe_ptr[wr_row] + 1;
    end
    pe_id <= cand_id[row_sel][pe_ptr[row_sel]];
    pe_sc <= cand_sc[row_sel][pe_ptr[row_sel]];
  end

  typedef struct { int start; int done_rel; int cnt; int unres; } txn_t;
  typedef struct { int cyc; int row; } wr_t;
  txn_t txnq[$];
  wr_t  wrq[$];
  int   sel_exp[int];
  int   busy_exp[int];

  int err = 0;
  int chk = 0;
  bit mon_en = 1'b0;
  int last_done_rel, last_cnt, last_unres;

  task automatic check(string name, int act, int exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: whole passes over the board with a claim dictionary; losers advance after the pass.
  task automatic model(int n, int st);
    int ptr [32];
    bit v [128];
    int s [128];
    int w [128];
    bit adv [32];
    int pass, wb, base, id, sc, loser, cnt;
    txn_t t;
    for (int i = 0; i < 32; i++) ptr[i] = 0;
    pass = 1; cnt = 0; wb = 0;
    if (n == 0) begin
      t.done_rel = 2;
    end else begin
      forever begin
        base = st + (pass - 1) * (n + 2);
        for (int i = 0; i < 128; i++) v[i] = 1'b0;
        for (int i = 0; i < 32; i++) adv[i] = 1'b0;
        wb = 0;
        for (int r = 0; r < n; r++) begin
          sel_exp[base + 1 + r] = r;
          id = int'(cand_id[r][ptr[r]]);
          sc = int'(cand_sc[r][ptr[r]]);
          if (id == 127) continue;
          if (!v[id]) begin
            v[id] = 1'b1; s[id] = sc; w[id] = r;
          end else begin
            if (sc < s[id]) begin
              loser = w[id]; s[id] = sc; w[id] = r;
            end else begin
              loser = r;
            end
            wrq.push_back('{base + r + 3, loser});
            adv[loser] = 1'b1;
            wb++;
          end
        end
        for (int i = 0; i < 32; i++) if (adv[i] && ptr[i] < NCAND - 1) ptr[i]++;
        cnt = (cnt + wb > 255) ? 255 : cnt + wb;
        if (wb > 0 && pass < MAXP) pass++;
        else break;
      end
      t.done_rel = pass * (n + 2) + 1;
    end
    t.start = st;
    t.cnt   = cnt;
    t.unres = (wb > 0) ? 1 : 0;
    for (int c = 1; c <= t.done_rel; c++) busy_exp[st + c] = 1;
    txnq.push_back(t);
  endtask

  // Monitor: compares every cycle's outputs against the expectations queued by the stimulus.
  txn_t mt;
  wr_t  mw;
  always @(negedge clk) begin
    if (mon_en) begin
      check("row_sel", int'(row_sel), sel_exp.exists(cyc) ? sel_exp[cyc] : 0);
      check("busy", int'(busy_cr), busy_exp.exists(cyc) ? 1 : 0);
      if (wr_stb) begin
        check("wr_data", int'(wr_dat), 1);
        if (wrq.size() == 0) begin
          check("wr_unexpected", cyc, -1);
        end else begin
          mw = wrq.pop_front();
          check("wr_cycle", cyc, mw.cyc);
          check("wr_row", int'(wr_row), mw.row);
        end
      end else begin
        check("wr_data_idle", int'(wr_dat), 0);
        check("wr_row_idle", int'(wr_row), 0);
      end
      if (done_cr) begin
        if (txnq.size() == 0) begin
          check("done_unexpected", cyc, -1);
        end else begin
          mt = txnq.pop_front();
          last_done_rel = cyc - mt.start;
          last_cnt      = int'(conflict_cnt);
          last_unres    = int'(unresolved);
          check("done_cycle", last_done_rel, mt.done_rel);
          check("conflict_cnt", last_cnt, mt.cnt);
          check("unresolved", last_unres, mt.unres);
        end
      end
    end
  end

  task automatic set_row(int r, int id0, int sc0, int id1, int sc1);
    cand_id[r][0] = 7'(id0);
    cand_sc[r][0] = 32'(sc0);
    for (int k = 1; k < NCAND; k++) begin
      cand_id[r][k] = 7'(id1);
      cand_sc[r][k] = 32'(sc1);
    end
  endtask

  task automatic run(int n, bit extra);
    int k;
    @(negedge clk);
    num_of_rows = 5'(n);
    start_cr = 1'b1;
    model(n, cyc);
    @(negedge clk);
    start_cr = extra;
    @(negedge clk);
    start_cr = 1'b0;
    k = 0;
    while (txnq.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (txnq.size() != 0) begin
      check("timeout_pending", txnq.size(), 0);
      txnq.delete();
    end
    check("writes_consumed", wrq.size(), 0);
    wrq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_row_sel"}, int'(row_sel), 0);
    check({tag, "_wr"}, int'(wr_stb), 0);
    check({tag, "_wr_dat"}, int'(wr_dat), 0);
    check({tag, "_wr_row"}, int'(wr_row), 0);
    check({tag, "_busy"}, int'(busy_cr), 0);
    check({tag, "_done"}, int'(done_cr), 0);
    check({tag, "_cnt"}, int'(conflict_cnt), 0);
    check({tag, "_unres"}, int'(unresolved), 0);
  endtask

  initial begin
    reset_N = 1'b0;
    start_cr = 1'b0;
    num_of_rows = '0;
    for (int r = 0; r < 32; r++) set_row(r, 127, 0, 127, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_N = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Distinct IDs: no conflicts.
    set_row(0, 5, 9, 5, 9); set_row(1, 6, 1, 6, 1); set_row(2, 7, 30, 7, 30);
    run(3, 1'b0);
    check("t1_done", last_done_rel, 6);
    check("t1_cnt", last_cnt, 0);

    // Later row better: earlier row falls back to a free ID.
    set_row(0, 4, 10, 9, 10); set_row(1, 4, 3, 4, 3);
    run(2, 1'b0);
    check("t2_done", last_done_rel, 9);
    check("t2_cnt", last_cnt, 1);

    // Persistent tie: pass limit reached, unresolved.
    set_row(0, 4, 7, 4, 7); set_row(1, 4, 7, 4, 7);
    run(2, 1'b0);
    check("t3_done", last_done_rel, 17);
    check("t3_cnt", last_cnt, 4);
    check("t3_unres", last_unres, 1);

    // No-match IDs are skipped.
    set_row(0, 127, 1, 127, 1); set_row(1, 127, 1, 127, 1); set_row(2, 2, 5, 2, 5);
    run(3, 1'b0);
    check("t4_done", last_done_rel, 6);
    check("t4_cnt", last_cnt, 0);

    // Empty board, with a second start while busy.
    run(0, 1'b1);
    check("t5_done", last_done_rel, 2);

    // Reset in cycle 3 of an N=4 scan.
    mon_en = 1'b0;
    for (int r = 0; r < 4; r++) set_row(r, 4, 1, 4, 1);
    @(negedge clk);
    num_of_rows = 5'd4;
    start_cr = 1'b1;
    @(negedge clk);
    start_cr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_N = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    set_row(0, 4, 10, 9, 10); set_row(1, 4, 3, 4, 3);
    run(2, 1'b0);
    check("t6_done", last_done_rel, 9);
    check("t6_cnt", last_cnt, 1);

    // Randomized boards against the reference model.
    for (int it = 0; it < 30; it++) begin
      int n;
      n = int'($urandom_range(0, 8));
      for (int r = 0; r < 32; r++) begin
        for (int k = 0; k < NCAND; k++) begin
          cand_id[r][k] = ($urandom_range(0, 5) == 0) ? 7'd127 : 7'($urandom_range(0, 4));
          cand_sc[r][k] = 32'($urandom_range(0, 15));
        end
      end
      run(n, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
